mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one external single-port memory bus between the instruction-fetch port (pc_reg/if_id side)
//  and the data port (mem stage), replacing the separate ROM/RAM ports at the CPU top.
//  Serialises requests via a req/ack handshake, holds read results stable, and raises stallreq_o to ctrl
//  until every enabled requester of the current pipeline cycle has been served. Data has priority over fetch.
// PARAMETERS
//  TIMEOUT  255  wait cycles for bus_ack_i before abort; 0 = no timeout (wait forever)
// PORTS
//  clk           in   1   clock, all state on rising edge
//  rst           in   1   asynchronous, active-low reset
//  inst_ce_i     in   1   fetch request enable
//  inst_addr_i   in   32  fetch address (pc)
//  inst_data_o   out  32  fetched instruction (held register)
//  data_ce_i     in   1   data access enable
//  data_we_i     in   1   1 = store, 0 = load
//  data_sel_i    in   4   byte lanes
//  data_addr_i   in   32  data address
//  data_wdata_i  in   32  store data
//  data_rdata_o  out  32  load data (held register)
//  bus_req_o     out  1   bus request (registered)
//  bus_we_o      out  1   bus write (registered)
//  bus_sel_o     out  4   bus byte lanes (registered; 4'b1111 for fetch)
//  bus_addr_o    out  32  bus address (registered)
//  bus_wdata_o   out  32  bus write data (registered)
//  bus_ack_i     in   1   slave completion; sampled only while bus_req_o=1
//  bus_rdata_i   in   32  slave read data, valid with bus_ack_i
//  stallreq_o    out  1   pipeline stall request to ctrl
//  bus_err_o     out  1   one-cycle pulse on timeout abort
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; bus_req_o/bus_we_o/bus_err_o=0; bus_sel_o/addr/wdata=0;
//   inst_data_o=data_rdata_o=0; inst_done=data_done=0; wait counter=0. Mid-transaction reset drops bus_req_o at once.
//  States: IDLE, D_REQ, I_REQ.
//  stallreq_o = (data_ce_i & ~data_done) | (inst_ce_i & ~inst_done), combinational.
//  IDLE: if data_ce_i & ~data_done -> D_REQ; else if inst_ce_i & ~inst_done -> I_REQ; bus fields loaded
//   from the chosen requester on the same edge, bus_req_o<=1.
//  IDLE with stallreq_o=0: pipeline advances this edge; clear inst_done, data_done.
//  D_REQ/I_REQ: bus_* held constant while bus_req_o=1. On bus_ack_i: set <port>_done; loads capture
//   bus_rdata_i into data_rdata_o, fetches into inst_data_o; stores leave data_rdata_o unchanged.
//   Next: if other port enabled and not done -> its REQ state directly (bus_req_o stays 1, fields reloaded);
//   else IDLE, bus_req_o<=0.
//  Wait counter: cleared on entering a REQ state, +1 per cycle without ack. TIMEOUT>0 and count==TIMEOUT
//   with no ack: abort as if acked with read data 32'h0, bus_err_o=1 for one cycle. Ack in that same cycle wins (no error).
//  bus_ack_i while bus_req_o=0 is ignored.
//  Requester inputs are sampled only at the IDLE/REQ-entry edge; pipeline is stalled, so they are stable.
//  Zero-wait latency: single access -> stallreq_o high 2 cycles; fetch+load -> 3 cycles.
//  ce low on both ports: stallreq_o=0, FSM stays IDLE, no bus activity.
// TESTING
//  T1 reset: rst=0 during D_REQ with bus_req_o=1 -> bus_req_o=0 same cycle, all outputs 0, stallreq_o follows ce.
//  T2 fetch only, ack immediate: inst_addr=0x100, rdata=0x24010005 -> bus_addr_o=0x100, sel=1111, stallreq 2 cycles,
//     inst_data_o=0x24010005.
//  T3 fetch+load same cycle, ack 3 wait cycles each: data cycle first (addr 0x2000), then fetch, req high throughout,
//     data_rdata_o=ack value, stallreq drops after both.
//  T4 store: we=1, sel=0011, wdata=0xDEADBEEF -> bus_we_o=1, fields held until ack, data_rdata_o unchanged.
//  T5 timeout TIMEOUT=4, no ack -> abort after 4 wait cycles, bus_err_o 1-cycle pulse, data_rdata_o=0, stall released.
//  T6 ack on the timeout cycle -> normal completion, bus_err_o stays 0.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shares one single-port memory bus between the instruction-fetch and data ports.
// Data has priority; the pipeline is stalled until every enabled port of the current cycle is served.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_ce_i,
  input  logic [31:0] inst_addr_i,
  output logic [31:0] inst_data_o,
  input  logic        data_ce_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_sel_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] data_wdata_i,
  output logic [31:0] data_rdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i,
  output logic        stallreq_o,
  output logic        bus_err_o
);

  typedef enum logic [1:0] {S_IDLE, S_DREQ, S_IREQ} state_t;

  localparam int unsigned CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_inst_done;
  logic          r_data_done;
  logic [CW-1:0] r_cnt;
  logic          r_req;
  logic          r_we;
  logic [3:0]    r_sel;
  logic [31:0]   r_addr;
  logic [31:0]   r_wdata;
  logic [31:0]   r_inst_data;
  logic [31:0]   r_data_rdata;
  logic          r_err;

  logic          w_d_pend;
  logic          w_i_pend;
  logic          w_tmo;
  logic          w_fin;
  logic          w_load_d;
  logic          w_load_i;
  logic [31:0]   w_rd;

  assign w_d_pend = data_ce_i & ~r_data_done;
  assign w_i_pend = inst_ce_i & ~r_inst_done;
  // A same-cycle ack takes precedence over the timeout abort.
  assign w_tmo    = (TIMEOUT != 0) && (r_cnt == TMO) && !bus_ack_i;
  assign w_fin    = bus_ack_i | w_tmo;
  assign w_rd     = bus_ack_i ? bus_rdata_i : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_d_pend)      w_state_nxt = S_DREQ;
        else if (w_i_pend) w_state_nxt = S_IREQ;
      end
      S_DREQ: begin
        if (w_fin) w_state_nxt = w_i_pend ? S_IREQ : S_IDLE;
      end
      S_IREQ: begin
        if (w_fin) w_state_nxt = w_d_pend ? S_DREQ : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    stallreq_o = w_d_pend | w_i_pend;
    w_load_d   = (w_state_nxt == S_DREQ) && (r_state != S_DREQ);
    w_load_i   = (w_state_nxt == S_IREQ) && (r_state != S_IREQ);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req        <= 1'b0;
      r_we         <= 1'b0;
      r_sel        <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_cnt        <= '0;
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
      r_inst_data  <= '0;
      r_data_rdata <= '0;
      r_err        <= 1'b0;
    end else begin
      r_err <= (r_state != S_IDLE) && w_tmo;
      if (w_load_d) begin
        r_req   <= 1'b1;
        r_we    <= data_we_i;
        r_sel   <= data_sel_i;
        r_addr  <= data_addr_i;
        r_wdata <= data_wdata_i;
        r_cnt   <= '0;
      end else if (w_load_i) begin
        r_req   <= 1'b1;
        r_we    <= 1'b0;
        r_sel   <= '1;
        r_addr  <= inst_addr_i;
        r_wdata <= '0;
        r_cnt   <= '0;
      end else if (r_state != S_IDLE) begin
        if (w_fin)              r_req <= 1'b0;
        else if (TIMEOUT != 0)  r_cnt <= r_cnt + CW'(1);
      end

      if (r_state == S_DREQ && w_fin) begin
        r_data_done <= 1'b1;
        if (!r_we) r_data_rdata <= w_rd;
      end
      if (r_state == S_IREQ && w_fin) begin
        r_inst_done <= 1'b1;
        r_inst_data <= w_rd;
      end
      // Both ports served: the pipeline advances on this edge.
      if (r_state == S_IDLE && !stallreq_o) begin
        r_inst_done <= 1'b0;
        r_data_done <= 1'b0;
      end
    end
  end

  assign bus_req_o    = r_req;
  assign bus_we_o     = r_we;
  assign bus_sel_o    = r_sel;
  assign bus_addr_o   = r_addr;
  assign bus_wdata_o  = r_wdata;
  assign inst_data_o  = r_inst_data;
  assign data_rdata_o = r_data_rdata;
  assign bus_err_o    = r_err;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: acts as pipeline and bus slave, checks each pipeline step
// against a transaction-level model (ordering, stall length, timeout aborts, held read data).
module tb_mem_bus_arbiter;

  localparam int unsigned T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ce_i;
  logic [31:0] inst_addr_i;
  logic [31:0] inst_data_o;
  logic        data_ce_i;
  logic        data_we_i;
  logic [3:0]  data_sel_i;
  logic [31:0] data_addr_i;
  logic [31:0] data_wdata_i;
  logic [31:0] data_rdata_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic        bus_ack_i;
  logic [31:0] bus_rdata_i;
  logic        stallreq_o;
  logic        bus_err_o;

  int n_chk  = 0;
  int n_fail = 0;
  logic [31:0] exp_inst = '0;
  logic [31:0] exp_drd  = '0;

  mem_bus_arbiter #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o),
    .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i),
    .stallreq_o(stallreq_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // One pipeline step: data access (if enabled) then fetch (if enabled); slave acks after dly wait cycles.
  task automatic do_step(input bit ice, input bit dce, input bit we, input logic [3:0] sel,
                         input logic [31:0] daddr, input logic [31:0] wdata, input logic [31:0] iaddr,
                         input int unsigned ddly, input int unsigned idly,
                         input logic [31:0] drd, input logic [31:0] ird);
    int unsigned ntx = 0;
    logic [31:0] t_addr[2];
    logic        t_we[2];
    logic [3:0]  t_sel[2];
    logic [31:0] t_wd[2];
    logic [31:0] t_rd[2];
    int unsigned t_dly[2];
    bit          t_isd[2];
    int unsigned exp_stall = 0;
    int unsigned stall_n = 0;
    int unsigned k = 0;
    int unsigned w = 0;
    bit errexp = 0, done = 0, stall_seen, req_seen, ack_seen;
    logic [31:0] res;

    inst_ce_i = ice; inst_addr_i = iaddr;
    data_ce_i = dce; data_we_i = we; data_sel_i = sel;
    data_addr_i = daddr; data_wdata_i = wdata;

    if (dce) begin
      t_addr[ntx] = daddr; t_we[ntx] = we; t_sel[ntx] = sel; t_wd[ntx] = wdata;
      t_rd[ntx] = drd; t_dly[ntx] = ddly; t_isd[ntx] = 1'b1; ntx++;
    end
    if (ice) begin
      t_addr[ntx] = iaddr; t_we[ntx] = 1'b0; t_sel[ntx] = 4'hF; t_wd[ntx] = '0;
      t_rd[ntx] = ird; t_dly[ntx] = idly; t_isd[ntx] = 1'b0; ntx++;
    end
    if (ntx != 0) begin
      exp_stall = 1;
      for (int unsigned j = 0; j < ntx; j++)
        exp_stall += ((t_dly[j] < T) ? t_dly[j] : T) + 1;
    end

    for (int c = 0; c < 100 && !done; c++) begin
      if (bus_req_o && k < ntx) begin
        bus_ack_i   = (w == t_dly[k]);
        bus_rdata_i = (w == t_dly[k]) ? t_rd[k] : $urandom;
      end else begin
        bus_ack_i   = ($urandom_range(0, 3) == 0);
        bus_rdata_i = $urandom;
      end
      @(negedge clk);
      chk("bus_err", bus_err_o, errexp);
      if (stallreq_o) stall_n++;
      if (bus_req_o) begin
        if (k >= ntx) chk("extra_req", bus_req_o, 1'b0);
        else begin
          chk("bus_addr", bus_addr_o, t_addr[k]);
          chk("bus_we", bus_we_o, t_we[k]);
          chk("bus_sel", bus_sel_o, t_sel[k]);
          if (t_isd[k]) chk("bus_wdata", bus_wdata_o, t_wd[k]);
        end
      end
      stall_seen = stallreq_o; req_seen = bus_req_o; ack_seen = bus_ack_i;
      @(posedge clk); #1;
      errexp = 0;
      if (req_seen && k < ntx) begin
        if (ack_seen || w == T) begin
          res = ack_seen ? t_rd[k] : '0;
          errexp = !ack_seen;
          if (t_isd[k]) begin
            if (!t_we[k]) exp_drd = res;
          end else exp_inst = res;
          k++; w = 0;
        end else w++;
      end
      if (!stall_seen) done = 1;
    end
    chk("step_bound", done, 1'b1);
    chk("stall_cycles", stall_n, exp_stall);
    chk("txn_count", k, ntx);
    chk("req_idle", bus_req_o, 1'b0);
    chk("inst_data", inst_data_o, exp_inst);
    chk("data_rdata", data_rdata_o, exp_drd);
  endtask

  initial begin
    rst = 1'b0;
    inst_ce_i = 0; inst_addr_i = '0; data_ce_i = 0; data_we_i = 0;
    data_sel_i = '0; data_addr_i = '0; data_wdata_i = '0;
    bus_ack_i = 0; bus_rdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", bus_req_o, 1'b0);
    chk("rst_addr", bus_addr_o, 32'h0);
    chk("rst_sel", bus_sel_o, 4'h0);
    chk("rst_inst", inst_data_o, 32'h0);
    chk("rst_drd", data_rdata_o, 32'h0);
    chk("rst_err", bus_err_o, 1'b0);
    chk("rst_stall", stallreq_o, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;

    // T1: reset while a load is on the bus
    data_ce_i = 1; data_addr_i = 32'h3000; data_sel_i = 4'hF;
    @(posedge clk); #1;
    chk("t1_req_up", bus_req_o, 1'b1);
    chk("t1_addr", bus_addr_o, 32'h3000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("t1_req_drop", bus_req_o, 1'b0);
    chk("t1_addr0", bus_addr_o, 32'h0);
    chk("t1_stall_ce", stallreq_o, 1'b1);
    data_ce_i = 0;
    #1;
    chk("t1_stall_noce", stallreq_o, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // T2 fetch only, T3 fetch+load with waits, T4 store, T5 timeout, T6 ack on timeout cycle
    do_step(1, 0, 0, 4'h0, 32'h0, 32'h0, 32'h100, 0, 0, 32'h0, 32'h24010005);
    do_step(1, 1, 0, 4'hF, 32'h2000, 32'h0, 32'h104, 3, 3, 32'hA5A5_1234, 32'h8C220000);
    do_step(0, 1, 1, 4'b0011, 32'h2004, 32'hDEADBEEF, 32'h0, 2, 0, 32'h1111_2222, 32'h0);
    do_step(0, 1, 0, 4'hF, 32'h2008, 32'h0, 32'h0, 9, 0, 32'h5555_AAAA, 32'h0);
    do_step(1, 0, 0, 4'h0, 32'h0, 32'h0, 32'h108, 0, T, 32'h0, 32'h0F0F_0F0F);
    do_step(0, 0, 0, 4'h0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 32'h0);

    for (int n = 0; n < 150; n++) begin
      do_step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 1),
              4'($urandom), $urandom, $urandom, $urandom,
              $urandom_range(0, 6), $urandom_range(0, 6), $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
